// File: rtl/draw_engine_pkg.sv
// Shared screen/sprite geometry, FSM state encodings and the clipping helper.
package draw_engine_pkg;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;
    localparam int SPR_W    = 16;
    localparam int SPR_H    = 16;
    localparam int COLOUR_W = 3;

    localparam logic [COLOUR_W-1:0] TRANSPARENT  = 3'b101;
    localparam logic [2:0]          SPR_ID_ENEMY = 3'b100;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_MAP_SCAN  = 3'd1;
    localparam logic [2:0] ST_LINK_SCAN = 3'd2;
    localparam logic [2:0] ST_EN_SELECT = 3'd3;
    localparam logic [2:0] ST_EN_SCAN   = 3'd4;
    localparam logic [2:0] ST_FLUSH     = 3'd5;
    localparam logic [2:0] ST_DONE      = 3'd6;
    localparam logic [2:0] ST_RELEASE   = 3'd7;

    typedef enum logic [1:0] {MODE_MAP, MODE_LINK, MODE_EN} draw_mode_e;

    // Sums are kept one bit wider than the screen coordinates so nothing wraps back on screen.
    function automatic logic on_screen(input logic [8:0] x, input logic [7:0] y);
        return (x < 9'(SCREEN_W)) && (y < 8'(SCREEN_H));
    endfunction

endpackage

// File: rtl/draw_engine_raster_counter.sv
// Row-major x/y raster counter; saturates on the last pixel so the address holds after a scan.
module raster_counter #(
    parameter int W = 16,
    parameter int H = 16,
    localparam int XW = $clog2(W),
    localparam int YW = $clog2(H)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en,
    input  logic          clr,
    output logic [XW-1:0] x,
    output logic [YW-1:0] y,
    output logic          last
);

    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;

    assign x    = x_q;
    assign y    = y_q;
    assign last = (x_q == XW'(W-1)) && (y_q == YW'(H-1));

    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (clr) begin
            x_d = '0;
            y_d = '0;
        end else if (en && !last) begin
            if (x_q == XW'(W-1)) begin
                x_d = '0;
                y_d = y_q + 1'b1;
            end else begin
                x_d = x_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

endmodule

// File: rtl/draw_engine.sv
// Draw-state responder: rasters map / Link / enemy sprites from ROM into the VGA adapter.
module draw_engine
    import draw_engine_pkg::*;
#(
    parameter int NUM_ENEMIES = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       draw_map,
    input  logic                       draw_link,
    input  logic                       draw_enemies,
    input  logic [7:0]                 link_x,
    input  logic [6:0]                 link_y,
    input  logic [1:0]                 link_frame,
    input  logic [8*NUM_ENEMIES-1:0]   enemy_x,
    input  logic [7*NUM_ENEMIES-1:0]   enemy_y,
    input  logic [NUM_ENEMIES-1:0]     enemy_alive,
    output logic [14:0]                map_rom_addr,
    input  logic [COLOUR_W-1:0]        map_rom_data,
    output logic [10:0]                spr_rom_addr,
    input  logic [COLOUR_W-1:0]        spr_rom_data,
    output logic [7:0]                 vga_x,
    output logic [6:0]                 vga_y,
    output logic [COLOUR_W-1:0]        vga_colour,
    output logic                       vga_plot,
    output logic                       draw_map_done,
    output logic                       draw_link_done,
    output logic                       draw_enemies_done
);

    localparam int SLOT_W = (NUM_ENEMIES > 1) ? $clog2(NUM_ENEMIES) : 1;

    logic [2:0]                        state_q, state_d;
    draw_mode_e                        mode_q, mode_d;
    logic [SLOT_W-1:0]                 slot_q, slot_d;
    logic [7:0]                        link_x_q, link_x_d;
    logic [6:0]                        link_y_q, link_y_d;
    logic [2:0]                        spr_id_q, spr_id_d;
    logic [NUM_ENEMIES-1:0][7:0]       enemy_x_q, enemy_x_d;
    logic [NUM_ENEMIES-1:0][6:0]       enemy_y_q, enemy_y_d;
    logic [NUM_ENEMIES-1:0]            alive_q, alive_d;

    logic       map_en, map_clr, map_last, spr_en, spr_clr, spr_last;
    logic [7:0] map_x;
    logic [6:0] map_y;
    logic [3:0] spr_col, spr_row;

    logic       plot_pend_q, plot_pend_d, plot_spr_q, plot_spr_d, plot_in_q, plot_in_d;
    logic [7:0] plot_x_q, plot_x_d;
    logic [6:0] plot_y_q, plot_y_d;

    logic                scanning, req_cur;
    logic [7:0]          org_x;
    logic [6:0]          org_y;
    logic [8:0]          sum_x;
    logic [7:0]          sum_y;
    logic [COLOUR_W-1:0] pix;

    raster_counter #(.W(SCREEN_W), .H(SCREEN_H)) u_map_cnt (
        .clk(clock), .reset(reset), .en(map_en), .clr(map_clr),
        .x(map_x), .y(map_y), .last(map_last)
    );

    raster_counter #(.W(SPR_W), .H(SPR_H)) u_spr_cnt (
        .clk(clock), .reset(reset), .en(spr_en), .clr(spr_clr),
        .x(spr_col), .y(spr_row), .last(spr_last)
    );

    assign map_rom_addr = 15'(map_y) * 15'(SCREEN_W) + 15'(map_x);
    assign spr_rom_addr = {spr_id_q, spr_row, spr_col};

    assign scanning = (state_q == ST_MAP_SCAN) || (state_q == ST_LINK_SCAN) || (state_q == ST_EN_SCAN);
    assign org_x    = (mode_q == MODE_LINK) ? link_x_q : enemy_x_q[slot_q];
    assign org_y    = (mode_q == MODE_LINK) ? link_y_q : enemy_y_q[slot_q];
    assign sum_x    = {1'b0, org_x} + {5'b0, spr_col};
    assign sum_y    = {1'b0, org_y} + {4'b0, spr_row};

    always_comb begin
        case (mode_q)
            MODE_MAP:  req_cur = draw_map;
            MODE_LINK: req_cur = draw_link;
            default:   req_cur = draw_enemies;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        slot_d    = slot_q;
        link_x_d  = link_x_q;
        link_y_d  = link_y_q;
        spr_id_d  = spr_id_q;
        enemy_x_d = enemy_x_q;
        enemy_y_d = enemy_y_q;
        alive_d   = alive_q;
        map_en    = 1'b0;
        map_clr   = 1'b0;
        spr_en    = 1'b0;
        spr_clr   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (draw_map) begin
                    mode_d  = MODE_MAP;
                    map_clr = 1'b1;
                    state_d = ST_MAP_SCAN;
                end else if (draw_link) begin
                    mode_d   = MODE_LINK;
                    link_x_d = link_x;
                    link_y_d = link_y;
                    spr_id_d = {1'b0, link_frame};
                    spr_clr  = 1'b1;
                    state_d  = ST_LINK_SCAN;
                end else if (draw_enemies) begin
                    mode_d    = MODE_EN;
                    enemy_x_d = enemy_x;
                    enemy_y_d = enemy_y;
                    alive_d   = enemy_alive;
                    spr_id_d  = SPR_ID_ENEMY;
                    slot_d    = '0;
                    state_d   = ST_EN_SELECT;
                end
            end
            ST_MAP_SCAN: begin
                map_en = 1'b1;
                if (map_last) state_d = ST_FLUSH;
            end
            ST_LINK_SCAN: begin
                spr_en = 1'b1;
                if (spr_last) state_d = ST_FLUSH;
            end
            ST_EN_SELECT: begin
                if (alive_q[slot_q]) begin
                    spr_clr = 1'b1;
                    state_d = ST_EN_SCAN;
                end else if (slot_q == SLOT_W'(NUM_ENEMIES-1)) begin
                    state_d = ST_FLUSH;
                end else begin
                    slot_d = slot_q + 1'b1;
                end
            end
            ST_EN_SCAN: begin
                spr_en = 1'b1;
                if (spr_last) begin
                    if (slot_q == SLOT_W'(NUM_ENEMIES-1)) begin
                        state_d = ST_FLUSH;
                    end else begin
                        slot_d  = slot_q + 1'b1;
                        state_d = ST_EN_SELECT;
                    end
                end
            end
            ST_FLUSH:   state_d = ST_DONE;
            ST_DONE:    state_d = ST_RELEASE;
            ST_RELEASE: if (!req_cur) state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // One-stage plot pipeline: coordinates travel alongside the ROM read latency.
    always_comb begin
        plot_pend_d = scanning;
        plot_spr_d  = plot_spr_q;
        plot_in_d   = plot_in_q;
        plot_x_d    = plot_x_q;
        plot_y_d    = plot_y_q;
        if (state_q == ST_MAP_SCAN) begin
            plot_spr_d = 1'b0;
            plot_in_d  = 1'b1;
            plot_x_d   = map_x;
            plot_y_d   = map_y;
        end else if (scanning) begin
            plot_spr_d = 1'b1;
            plot_in_d  = on_screen(sum_x, sum_y);
            plot_x_d   = sum_x[7:0];
            plot_y_d   = sum_y[6:0];
        end
    end

    assign pix        = plot_spr_q ? spr_rom_data : map_rom_data;
    assign vga_plot   = plot_pend_q && plot_in_q && (!plot_spr_q || (pix != TRANSPARENT));
    assign vga_colour = vga_plot ? pix : '0;
    assign vga_x      = plot_x_q;
    assign vga_y      = plot_y_q;

    assign draw_map_done     = (state_q == ST_DONE) && (mode_q == MODE_MAP);
    assign draw_link_done    = (state_q == ST_DONE) && (mode_q == MODE_LINK);
    assign draw_enemies_done = (state_q == ST_DONE) && (mode_q == MODE_EN);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            mode_q      <= MODE_MAP;
            slot_q      <= '0;
            link_x_q    <= '0;
            link_y_q    <= '0;
            spr_id_q    <= '0;
            enemy_x_q   <= '0;
            enemy_y_q   <= '0;
            alive_q     <= '0;
            plot_pend_q <= 1'b0;
            plot_spr_q  <= 1'b0;
            plot_in_q   <= 1'b0;
            plot_x_q    <= '0;
            plot_y_q    <= '0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            slot_q      <= slot_d;
            link_x_q    <= link_x_d;
            link_y_q    <= link_y_d;
            spr_id_q    <= spr_id_d;
            enemy_x_q   <= enemy_x_d;
            enemy_y_q   <= enemy_y_d;
            alive_q     <= alive_d;
            plot_pend_q <= plot_pend_d;
            plot_spr_q  <= plot_spr_d;
            plot_in_q   <= plot_in_d;
            plot_x_q    <= plot_x_d;
            plot_y_q    <= plot_y_d;
        end
    end

endmodule

// File: tb/tb_draw_engine.sv
// Randomized self-checking bench for draw_engine against a plot-list reference model.
module tb_draw_engine;

    logic        clock = 1'b0;
    logic        reset;
    logic        draw_map, draw_link, draw_enemies;
    logic [7:0]  link_x;
    logic [6:0]  link_y;
    logic [1:0]  link_frame;
    logic [31:0] enemy_x;
    logic [27:0] enemy_y;
    logic [3:0]  enemy_alive;
    logic [14:0] map_rom_addr;
    logic [2:0]  map_rom_data;
    logic [10:0] spr_rom_addr;
    logic [2:0]  spr_rom_data;
    logic [7:0]  vga_x;
    logic [6:0]  vga_y;
    logic [2:0]  vga_colour;
    logic        vga_plot;
    logic        draw_map_done, draw_link_done, draw_enemies_done;

    draw_engine #(.NUM_ENEMIES(4)) dut (
        .clock(clock), .reset(reset),
        .draw_map(draw_map), .draw_link(draw_link), .draw_enemies(draw_enemies),
        .link_x(link_x), .link_y(link_y), .link_frame(link_frame),
        .enemy_x(enemy_x), .enemy_y(enemy_y), .enemy_alive(enemy_alive),
        .map_rom_addr(map_rom_addr), .map_rom_data(map_rom_data),
        .spr_rom_addr(spr_rom_addr), .spr_rom_data(spr_rom_data),
        .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_plot(vga_plot),
        .draw_map_done(draw_map_done), .draw_link_done(draw_link_done),
        .draw_enemies_done(draw_enemies_done)
    );

    always #5 clock = ~clock;

    typedef struct packed {logic [7:0] x; logic [6:0] y; logic [2:0] c;} plot_t;

    int    n_chk = 0, n_fail = 0;
    bit    opaque = 1'b0;
    logic [1:0] cur_frame;
    plot_t got[$];
    plot_t exp_q[$];
    int    done_at, n_done, n_other, n_late, addr_bad;

    function automatic logic [2:0] srom(input logic [10:0] a);
        if (opaque) return 3'b010;
        return a[2:0] ^ a[5:3] ^ a[8:6];
    endfunction

    always @(posedge clock) begin
        map_rom_data <= map_rom_addr[2:0];
        spr_rom_data <= srom(spr_rom_addr);
    end

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_chk++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic mdl_map();
        exp_q.delete();
        for (int y = 0; y < 120; y++)
            for (int x = 0; x < 160; x++)
                exp_q.push_back({8'(x), 7'(y), 3'((y*160 + x) % 8)});
    endtask

    task automatic mdl_sprite(input int ox, input int oy, input logic [2:0] id);
        logic [2:0] col;
        for (int r = 0; r < 16; r++)
            for (int c = 0; c < 16; c++) begin
                col = srom({id, 4'(r), 4'(c)});
                if (col != 3'b101 && ox + c < 160 && oy + r < 120)
                    exp_q.push_back({8'(ox + c), 7'(oy + r), col});
            end
    endtask

    task automatic cmp_plots(input string tag);
        int bad = 0;
        chk({tag, "_nplots"}, got.size(), exp_q.size());
        for (int i = 0; i < got.size() && i < exp_q.size(); i++)
            if (got[i] != exp_q[i]) bad++;
        chk({tag, "_pixels"}, bad, 0);
    endtask

    // req = {enemies, link, map}; want = index of the done expected; hold = cycles to keep req past done.
    task automatic run(input logic [2:0] req, input int want, input int hold, input bit scramble);
        logic [2:0] d;
        got.delete();
        done_at = -1; n_done = 0; n_other = 0; n_late = 0; addr_bad = 0;
        @(posedge clock); #1;
        {draw_enemies, draw_link, draw_map} = req;
        for (int c = 0; c < 20000; c++) begin
            @(negedge clock);
            d = {draw_enemies_done, draw_link_done, draw_map_done};
            if (vga_plot) begin
                got.push_back({vga_x, vga_y, vga_colour});
                if (done_at >= 0) n_late++;
            end
            if (req == 3'b010 && c >= 1 && c <= 256 &&
                spr_rom_addr != (11'({1'b0, cur_frame}) << 8) + 11'(c - 1)) addr_bad++;
            if (d[want]) begin
                if (done_at < 0) done_at = c;
                n_done++;
            end
            if ((d & ~(3'b001 << want)) != 3'b000) n_other++;
            if (scramble && c == 3) begin
                link_x = 8'($urandom); link_y = 7'($urandom); link_frame = 2'($urandom);
                enemy_x = $urandom; enemy_y = 28'($urandom); enemy_alive = 4'($urandom);
            end
            if (done_at >= 0 && c == done_at + hold) {draw_enemies, draw_link, draw_map} = 3'b000;
            if (done_at >= 0 && c >= done_at + hold + 4) break;
        end
        {draw_enemies, draw_link, draw_map} = 3'b000;
        chk("done_seen", (done_at >= 0) ? 1 : 0, 1);
    endtask

    initial begin
        int found, col, bad, lx, ly, pop, edone;
        logic [3:0] alive;
        reset = 1'b1; {draw_map, draw_link, draw_enemies} = 3'b000;
        link_x = '0; link_y = '0; link_frame = '0; enemy_x = '0; enemy_y = '0; enemy_alive = '0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("reset_outputs", {map_rom_addr, spr_rom_addr, vga_x, vga_y, vga_colour, vga_plot,
                              draw_map_done, draw_link_done, draw_enemies_done}, 0);
        reset = 1'b0;

        // full map
        mdl_map();
        run(3'b001, 0, 0, 1'b0);
        chk("map_done_cycle", done_at, 19202);
        chk("map_other_done", n_other, 0);
        cmp_plots("map");
        found = 0; col = -1;
        foreach (got[i]) if (got[i].x == 8'd37 && got[i].y == 7'd5) begin found++; col = got[i].c; end
        chk("map_37_5_found", found, 1);
        chk("map_37_5_colour", col, (5*160 + 37) % 8);

        // Link at (10,20), frame 2, patterned ROM; inputs scrambled after start
        opaque = 1'b0; link_x = 8'd10; link_y = 7'd20; link_frame = 2'd2; cur_frame = 2'd2;
        exp_q.delete(); mdl_sprite(10, 20, 3'b010);
        run(3'b010, 1, 0, 1'b1);
        chk("link_done_cycle", done_at, 258);
        chk("link_addr_seq", addr_bad, 0);
        cmp_plots("link");
        bad = 0;
        foreach (got[i])
            if (got[i].c == 3'b101 || got[i].x < 10 || got[i].x > 25 || got[i].y < 20 || got[i].y > 35) bad++;
        chk("link_box_transp", bad, 0);

        // clipping at (152,115)
        opaque = 1'b1; link_x = 8'd152; link_y = 7'd115; link_frame = 2'd1; cur_frame = 2'd1;
        exp_q.delete(); mdl_sprite(152, 115, 3'b001);
        run(3'b010, 1, 0, 1'b0);
        chk("clip_nplots", got.size(), 40);
        bad = 0;
        foreach (got[i]) if (got[i].x >= 160 || got[i].y >= 120) bad++;
        chk("clip_offscreen", bad, 0);
        cmp_plots("clip");

        // enemies alive=0101
        enemy_alive = 4'b0101;
        enemy_x = {8'($urandom), 8'd50, 8'($urandom), 8'd0};
        enemy_y = {7'($urandom), 7'd50, 7'($urandom), 7'd0};
        exp_q.delete(); mdl_sprite(0, 0, 3'b100); mdl_sprite(50, 50, 3'b100);
        run(3'b100, 2, 0, 1'b1);
        chk("en_done_cycle", done_at, 518);
        chk("en_nplots", got.size(), 512);
        cmp_plots("en");

        enemy_alive = 4'b0000;
        run(3'b100, 2, 0, 1'b0);
        chk("en_dead_done_cycle", done_at, 6);
        chk("en_dead_nplots", got.size(), 0);

        // held request must not restart
        link_x = 8'd30; link_y = 7'd40; link_frame = 2'd0; cur_frame = 2'd0;
        run(3'b010, 1, 5, 1'b0);
        chk("hold_ndone", n_done, 1);
        chk("hold_late_plots", n_late, 0);
        chk("hold_nplots", got.size(), 256);

        // map beats link
        mdl_map();
        run(3'b011, 0, 0, 1'b0);
        chk("prio_map_done", done_at, 19202);
        chk("prio_no_link_done", n_other, 0);
        cmp_plots("prio");

        // reset in cycle 1000 of a map draw
        n_done = 0;
        @(posedge clock); #1;
        draw_map = 1'b1;
        for (int c = 0; c <= 1000; c++) begin
            @(negedge clock);
            if (draw_map_done) n_done++;
            if (c == 1000) reset = 1'b1;
        end
        @(negedge clock);
        chk("midreset_outputs", {map_rom_addr, spr_rom_addr, vga_x, vga_y, vga_colour, vga_plot,
                                 draw_map_done, draw_link_done, draw_enemies_done}, 0);
        draw_map = 1'b0;
        repeat (3) begin @(negedge clock); if (draw_map_done) n_done++; end
        reset = 1'b0;
        repeat (3) begin @(negedge clock); if (draw_map_done) n_done++; end
        chk("midreset_no_done", n_done, 0);
        mdl_map();
        run(3'b001, 0, 0, 1'b0);
        chk("postreset_done", done_at, 19202);
        cmp_plots("postreset");

        // randomized sprite draws
        for (int it = 0; it < 8; it++) begin
            opaque = 1'($urandom);
            exp_q.delete();
            if ($urandom_range(1, 0) == 0) begin
                lx = $urandom_range(255, 0); ly = $urandom_range(127, 0);
                link_x = 8'(lx); link_y = 7'(ly); link_frame = 2'($urandom); cur_frame = link_frame;
                mdl_sprite(lx, ly, {1'b0, cur_frame});
                run(3'b010, 1, 0, 1'b1);
                chk("rnd_link_done", done_at, 258);
                chk("rnd_link_addr", addr_bad, 0);
                cmp_plots("rnd_link");
            end else begin
                alive = 4'($urandom); enemy_alive = alive;
                enemy_x = $urandom; enemy_y = 28'($urandom);
                pop = 0;
                for (int s = 0; s < 4; s++)
                    if (alive[s]) begin
                        pop++;
                        mdl_sprite(int'(enemy_x[8*s +: 8]), int'(enemy_y[7*s +: 7]), 3'b100);
                    end
                edone = 4 + 256*pop + 2;
                run(3'b100, 2, 0, 1'b1);
                chk("rnd_en_done", done_at, edone);
                cmp_plots("rnd_en");
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
